pll_rstgen_seq: RTL and testbench

PLL_RSTGEN_SEQ -- requirements
Module: pll_rstgen_seq

---
 rtl/pll_rstgen_pkg.sv | 22 ++
 rtl/pll_rstgen_sync2.sv | 25 ++
 rtl/pll_rstgen_seq.sv | 136 +++++++++++++
 tb/tb_pll_rstgen_seq.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_rstgen_pkg.sv
// Shared types and helpers for the PLL reset sequencer: FSM state encoding
// and the lock-loss counter limits.
package pll_rstgen_pkg;

  typedef enum logic [1:0] {
    ST_PWRDN     = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  localparam int unsigned  LOSS_CNT_W   = 8;
  localparam logic [7:0]   LOSS_CNT_MAX = 8'hFF;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_rstgen_sync2.sv
// Two-flop synchronizer with synchronous clear; also usable by the reset
// consumers in each PLL output domain.
module pll_rstgen_sync2 (
  input  logic i_clk,
  input  logic i_srst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_rstgen_seq.sv
// PLL power-up / lock-qualification reset sequencer. Define PLL_RSTGEN_RETRY_EN
// to restart the PLL when WAIT_LOCK lasts TIMEOUT_CYCLES cycles.
module pll_rstgen_seq
  import pll_rstgen_pkg::*;
#(
  parameter int unsigned PWRDN_CYCLES   = 16,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic       sys_clk_i,
  input  logic       sys_rst_i,
  input  logic       pll_lock_i,
  output logic       pll_pwrdn_n_o,
  output logic       rst_o,
  output logic       rst_done_o,
  output logic [7:0] lock_loss_cnt_o
);

  localparam int unsigned CNT_MAX = max3(PWRDN_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES);
  localparam int unsigned CNT_W   = ($clog2(CNT_MAX) < 1) ? 1 : $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] PWRDN_LOAD  = CNT_W'(PWRDN_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LOAD = CNT_W'(STABLE_CYCLES - 1);
`ifdef PLL_RSTGEN_RETRY_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  state_t                r_state;
  state_t                w_state_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_next;
  logic                  w_cnt_zero;
  logic                  w_lock_s;
  logic                  w_loss_inc;
  logic                  r_pwrdn_n;
  logic                  r_rst;
  logic                  r_done;
  logic [LOSS_CNT_W-1:0] r_loss_cnt;
  logic                  w_pwrdn_n_next;
  logic                  w_rst_next;
  logic                  w_done_next;

  pll_rstgen_sync2 u_lock_sync (
    .i_clk  (sys_clk_i),
    .i_srst (sys_rst_i),
    .i_d    (pll_lock_i),
    .o_q    (w_lock_s)
  );

  assign w_cnt_zero = (r_cnt == '0);

  // State register; outputs are registered from the next state so they
  // change on the same edge as the state and cannot glitch.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      r_state    <= ST_PWRDN;
      r_cnt      <= PWRDN_LOAD;
      r_pwrdn_n  <= 1'b0;
      r_rst      <= 1'b1;
      r_done     <= 1'b0;
      r_loss_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_pwrdn_n <= w_pwrdn_n_next;
      r_rst     <= w_rst_next;
      r_done    <= w_done_next;
      if (w_loss_inc && (r_loss_cnt != LOSS_CNT_MAX)) begin
        r_loss_cnt <= r_loss_cnt + 1'b1;
      end
    end
  end

  // Loss of lock is checked before counter expiry, so a lock drop on the
  // final STABLE cycle falls back to WAIT_LOCK.
  always_comb begin
    w_state_next = r_state;
    w_loss_inc   = 1'b0;
    case (r_state)
      ST_PWRDN: begin
        if (w_cnt_zero) w_state_next = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (w_lock_s) begin
          w_state_next = ST_STABLE;
        end
`ifdef PLL_RSTGEN_RETRY_EN
        else if (w_cnt_zero) begin
          w_state_next = ST_PWRDN;
        end
`endif
      end
      ST_STABLE: begin
        if (!w_lock_s)       w_state_next = ST_WAIT_LOCK;
        else if (w_cnt_zero) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (!w_lock_s) begin
          w_state_next = ST_PWRDN;
          w_loss_inc   = 1'b1;
        end
      end
      default: w_state_next = ST_PWRDN;
    endcase
  end

  // Shared down-counter: reloaded on every state entry, else counts to zero.
  always_comb begin
    w_cnt_next = r_cnt;
    if (w_state_next != r_state) begin
      case (w_state_next)
        ST_PWRDN:     w_cnt_next = PWRDN_LOAD;
`ifdef PLL_RSTGEN_RETRY_EN
        ST_WAIT_LOCK: w_cnt_next = TIMEOUT_LOAD;
`else
        ST_WAIT_LOCK: w_cnt_next = '0;
`endif
        ST_STABLE:    w_cnt_next = STABLE_LOAD;
        default:      w_cnt_next = '0;
      endcase
    end else if (!w_cnt_zero) begin
      w_cnt_next = r_cnt - 1'b1;
    end
  end

  always_comb begin
    w_pwrdn_n_next = (w_state_next != ST_PWRDN);
    w_rst_next     = (w_state_next != ST_RUN);
    w_done_next    = (w_state_next == ST_RUN);
  end

  assign pll_pwrdn_n_o   = r_pwrdn_n;
  assign rst_o           = r_rst;
  assign rst_done_o      = r_done;
  assign lock_loss_cnt_o = r_loss_cnt;

endmodule

// File: tb/tb_pll_rstgen_seq.sv
// Self-checking bench for pll_rstgen_seq: directed timing scenarios plus a
// randomized lock stream compared against a behavioural phase model.
module tb_pll_rstgen_seq;

  localparam int P_PWRDN   = 4;
  localparam int P_STABLE  = 8;
  localparam int P_TIMEOUT = 32;
`ifdef PLL_RSTGEN_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       sys_rst = 1'b0;
  logic       lock = 1'b0;
  logic       pll_pwrdn_n_o;
  logic       rst_o;
  logic       rst_done_o;
  logic [7:0] lock_loss_cnt_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pll_rstgen_seq #(
    .PWRDN_CYCLES   (P_PWRDN),
    .STABLE_CYCLES  (P_STABLE),
    .TIMEOUT_CYCLES (P_TIMEOUT)
  ) dut (
    .sys_clk_i       (clk),
    .sys_rst_i       (sys_rst),
    .pll_lock_i      (lock),
    .pll_pwrdn_n_o   (pll_pwrdn_n_o),
    .rst_o           (rst_o),
    .rst_done_o      (rst_done_o),
    .lock_loss_cnt_o (lock_loss_cnt_o)
  );

  // Behavioural model: phase 0=powered down, 1=waiting, 2=qualifying, 3=running.
  // Lock is seen two edges late; running needs STABLE+1 consecutive lock samples.
  int m_phase   = 0;
  int m_elapsed = 0;
  int m_streak  = 0;
  int m_loss    = 0;
  bit m_s1      = 1'b0;
  bit m_s2      = 1'b0;

  always @(posedge clk) begin
    if (sys_rst) begin
      m_phase   <= 0;
      m_elapsed <= 0;
      m_streak  <= 0;
      m_loss    <= 0;
      m_s1      <= 1'b0;
      m_s2      <= 1'b0;
    end else begin
      m_s1 <= lock;
      m_s2 <= m_s1;
      case (m_phase)
        0: begin
          if (m_elapsed + 1 == P_PWRDN) begin
            m_phase <= 1; m_elapsed <= 0;
          end else m_elapsed <= m_elapsed + 1;
        end
        1: begin
          if (m_s2) begin
            m_phase <= 2; m_streak <= 1;
          end else if (RETRY && (m_elapsed + 1 == P_TIMEOUT)) begin
            m_phase <= 0; m_elapsed <= 0;
          end else m_elapsed <= m_elapsed + 1;
        end
        2: begin
          if (!m_s2) begin
            m_phase <= 1; m_elapsed <= 0;
          end else if (m_streak + 1 == P_STABLE + 1) m_phase <= 3;
          else m_streak <= m_streak + 1;
        end
        default: begin
          if (!m_s2) begin
            m_phase <= 0; m_elapsed <= 0;
            if (m_loss < 255) m_loss <= m_loss + 1;
          end
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    lock    = 1'b0;
    sys_rst = 1'b1;
    tick();
    tick();
    total++; if (pll_pwrdn_n_o !== 1'b0) begin bad++; $display("FAIL reset_pwrdn_n: got %b want 0", pll_pwrdn_n_o); end
    total++; if (rst_o !== 1'b1) begin bad++; $display("FAIL reset_rst: got %b want 1", rst_o); end
    total++; if (rst_done_o !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", rst_done_o); end
    total++; if (lock_loss_cnt_o !== 8'd0) begin bad++; $display("FAIL reset_loss_cnt: got %0d want 0", lock_loss_cnt_o); end
    sys_rst = 1'b0;
    $display("test_reset: done");
  endtask

  task automatic test_powerdown();
    for (int n = 1; n < P_PWRDN; n++) begin
      tick();
      total++; if (pll_pwrdn_n_o !== 1'b0) begin bad++; $display("FAIL pwrdn_low cyc%0d: got %b want 0", n, pll_pwrdn_n_o); end
    end
    tick();
    total++; if (pll_pwrdn_n_o !== 1'b1) begin bad++; $display("FAIL pwrdn_rise: got %b want 1", pll_pwrdn_n_o); end
    total++; if (rst_o !== 1'b1) begin bad++; $display("FAIL pwrdn_rst: got %b want 1", rst_o); end
    if (RETRY) begin
      for (int n = 1; n < P_TIMEOUT; n++) begin
        tick();
        total++; if (pll_pwrdn_n_o !== 1'b1) begin bad++; $display("FAIL wait_high cyc%0d: got %b want 1", n, pll_pwrdn_n_o); end
      end
      tick();
      total++; if (pll_pwrdn_n_o !== 1'b0) begin bad++; $display("FAIL retry_fall: got %b want 0", pll_pwrdn_n_o); end
    end else begin
      for (int n = 1; n <= 2 * P_TIMEOUT; n++) begin
        tick();
        total++; if (pll_pwrdn_n_o !== 1'b1) begin bad++; $display("FAIL wait_forever cyc%0d: got %b want 1", n, pll_pwrdn_n_o); end
      end
    end
    total++; if (rst_o !== 1'b1) begin bad++; $display("FAIL no_lock_rst: got %b want 1", rst_o); end
    $display("test_powerdown: done (retry=%0d)", RETRY);
  endtask

  task automatic test_lock_sequence();
    int n;
    lock = 1'b0; sys_rst = 1'b1; tick(); sys_rst = 1'b0;
    n = 0;
    while (pll_pwrdn_n_o !== 1'b1 && n < 20) begin tick(); n++; end
    total++; if (pll_pwrdn_n_o !== 1'b1) begin bad++; $display("FAIL seq_pwrdn_rise_timeout: got %b want 1", pll_pwrdn_n_o); end
    repeat (10) tick();
    lock = 1'b1;
    for (int k = 1; k <= P_STABLE + 2; k++) begin
      tick();
      total++; if (rst_o !== 1'b1) begin bad++; $display("FAIL seq_rst_early cyc%0d: got %b want 1", k, rst_o); end
    end
    tick();
    total++; if (rst_o !== 1'b0) begin bad++; $display("FAIL seq_rst_fall: got %b want 0", rst_o); end
    total++; if (rst_done_o !== 1'b1) begin bad++; $display("FAIL seq_done: got %b want 1", rst_done_o); end
    $display("test_lock_sequence: done");
  endtask

  task automatic test_stable_glitch();
    int n;
    lock = 1'b0; sys_rst = 1'b1; tick(); sys_rst = 1'b0;
    n = 0;
    while (pll_pwrdn_n_o !== 1'b1 && n < 20) begin tick(); n++; end
    total++; if (pll_pwrdn_n_o !== 1'b1) begin bad++; $display("FAIL glitch_pwrdn_rise_timeout: got %b want 1", pll_pwrdn_n_o); end
    repeat (2) tick();
    lock = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      total++; if (rst_o !== 1'b1) begin bad++; $display("FAIL glitch_rst_held cyc%0d: got %b want 1", k, rst_o); end
      if (k == 4) lock = 1'b0;
      if (k == 7) lock = 1'b1;
    end
    tick();
    total++; if (rst_o !== 1'b0) begin bad++; $display("FAIL glitch_rst_fall: got %b want 0", rst_o); end
    $display("test_stable_glitch: done");
  endtask

  task automatic test_lock_loss();
    int n;
    int exp;
    lock = 1'b1; sys_rst = 1'b1; tick(); sys_rst = 1'b0;
    n = 0;
    while (rst_o !== 1'b0 && n < 60) begin tick(); n++; end
    total++; if (rst_o !== 1'b0) begin bad++; $display("FAIL loss_run_timeout: got %b want 0", rst_o); end
    lock = 1'b0;
    repeat (2) tick();
    total++; if (rst_o !== 1'b0) begin bad++; $display("FAIL loss_rst_early: got %b want 0", rst_o); end
    tick();
    total++; if (rst_o !== 1'b1) begin bad++; $display("FAIL loss_rst_rise: got %b want 1", rst_o); end
    total++; if (rst_done_o !== 1'b0) begin bad++; $display("FAIL loss_done: got %b want 0", rst_done_o); end
    total++; if (lock_loss_cnt_o !== 8'd1) begin bad++; $display("FAIL loss_cnt_first: got %0d want 1", lock_loss_cnt_o); end
    total++; if (pll_pwrdn_n_o !== 1'b0) begin bad++; $display("FAIL loss_pwrdn: got %b want 0", pll_pwrdn_n_o); end
    for (int k = 1; k < P_PWRDN; k++) begin
      tick();
      total++; if (pll_pwrdn_n_o !== 1'b0) begin bad++; $display("FAIL loss_pwrdn_hold cyc%0d: got %b want 0", k, pll_pwrdn_n_o); end
    end
    tick();
    total++; if (pll_pwrdn_n_o !== 1'b1) begin bad++; $display("FAIL loss_pwrdn_release: got %b want 1", pll_pwrdn_n_o); end
    for (int i = 2; i <= 300; i++) begin
      lock = 1'b1;
      n = 0;
      while (rst_o !== 1'b0 && n < 60) begin tick(); n++; end
      total++; if (rst_o !== 1'b0) begin bad++; $display("FAIL loss_relock_timeout iter%0d: got %b want 0", i, rst_o); end
      lock = 1'b0;
      n = 0;
      while (rst_o !== 1'b1 && n < 10) begin tick(); n++; end
      exp = (i > 255) ? 255 : i;
      total++; if (lock_loss_cnt_o !== 8'(exp)) begin bad++; $display("FAIL loss_cnt iter%0d: got %0d want %0d", i, lock_loss_cnt_o, exp); end
    end
    $display("test_lock_loss: done, count=%0d", lock_loss_cnt_o);
  endtask

  task automatic test_reset_in_run();
    int n;
    lock = 1'b1;
    n = 0;
    while (rst_o !== 1'b0 && n < 60) begin tick(); n++; end
    total++; if (rst_o !== 1'b0) begin bad++; $display("FAIL rir_run_timeout: got %b want 0", rst_o); end
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    total++; if (rst_o !== 1'b1) begin bad++; $display("FAIL rir_rst: got %b want 1", rst_o); end
    total++; if (pll_pwrdn_n_o !== 1'b0) begin bad++; $display("FAIL rir_pwrdn: got %b want 0", pll_pwrdn_n_o); end
    total++; if (lock_loss_cnt_o !== 8'd0) begin bad++; $display("FAIL rir_loss_cnt: got %0d want 0", lock_loss_cnt_o); end
    total++; if (rst_done_o !== 1'b0) begin bad++; $display("FAIL rir_done: got %b want 0", rst_done_o); end
    for (int k = 2; k <= 4; k++) begin
      tick();
      total++; if (pll_pwrdn_n_o !== 1'b0) begin bad++; $display("FAIL rir_pwrdn_hold cyc%0d: got %b want 0", k, pll_pwrdn_n_o); end
    end
    tick();
    total++; if (pll_pwrdn_n_o !== 1'b1) begin bad++; $display("FAIL rir_pwrdn_release: got %b want 1", pll_pwrdn_n_o); end
    for (int k = 6; k <= 13; k++) begin
      tick();
      total++; if (rst_o !== 1'b1) begin bad++; $display("FAIL rir_rst_hold cyc%0d: got %b want 1", k, rst_o); end
    end
    tick();
    total++; if (rst_o !== 1'b0) begin bad++; $display("FAIL rir_rst_fall: got %b want 0", rst_o); end
    total++; if (rst_done_o !== 1'b1) begin bad++; $display("FAIL rir_done_again: got %b want 1", rst_done_o); end
    $display("test_reset_in_run: done");
  endtask

  task automatic test_random();
    int seg_left;
    sys_rst = 1'b1; tick(); sys_rst = 1'b0;
    seg_left = 0;
    for (int c = 0; c < 4000; c++) begin
      if (seg_left == 0) begin
        lock     = ($urandom_range(0, 99) < 70);
        seg_left = $urandom_range(1, 40);
      end
      seg_left--;
      sys_rst = ($urandom_range(0, 299) == 0);
      tick();
      total++; if (pll_pwrdn_n_o !== (m_phase != 0)) begin bad++; $display("FAIL rand_pwrdn cyc%0d: got %b want %b", c, pll_pwrdn_n_o, (m_phase != 0)); end
      total++; if (rst_o !== (m_phase != 3)) begin bad++; $display("FAIL rand_rst cyc%0d: got %b want %b", c, rst_o, (m_phase != 3)); end
      total++; if (rst_done_o !== (m_phase == 3)) begin bad++; $display("FAIL rand_done cyc%0d: got %b want %b", c, rst_done_o, (m_phase == 3)); end
      total++; if (lock_loss_cnt_o !== 8'(m_loss)) begin bad++; $display("FAIL rand_loss_cnt cyc%0d: got %0d want %0d", c, lock_loss_cnt_o, m_loss); end
    end
    sys_rst = 1'b0;
    $display("test_random: done, model loss count=%0d", m_loss);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_powerdown();
    test_lock_sequence();
    test_stable_glitch();
    test_lock_loss();
    test_reset_in_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
